// File: rtl/mmio_io_unit_if.sv
// Byte-stream interface between mmio_io_unit and the serial UART transmitter/receiver.
// The master side is the MMIO unit; the slave side is the serial block pair.
interface mmio_io_unit_if;
    logic [7:0] uart_tx_data_out;
    logic       uart_tx_data_out_valid;
    logic       uart_tx_data_out_ready;
    logic [7:0] uart_rx_data_in;
    logic       uart_rx_data_in_valid;
    logic       uart_rx_data_in_ready;

    modport master (
        output uart_tx_data_out,
        output uart_tx_data_out_valid,
        input  uart_tx_data_out_ready,
        input  uart_rx_data_in,
        input  uart_rx_data_in_valid,
        output uart_rx_data_in_ready
    );

    modport slave (
        input  uart_tx_data_out,
        input  uart_tx_data_out_valid,
        output uart_tx_data_out_ready,
        output uart_rx_data_in,
        output uart_rx_data_in_valid,
        input  uart_rx_data_in_ready
    );
endinterface

// File: rtl/mmio_io_unit.sv
// MMIO responder for the 0x8000_00xx window: UART TX/RX buffering, cycle/instret counters.
// Define MMIO_RX_FIFO_EN for an RX_FIFO_DEPTH-entry RX FIFO; otherwise RX holds a single byte.
module mmio_io_unit #(
    parameter int W_SIZE        = 32,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_SIZE-1:0] Addr,
    input  logic [W_SIZE-1:0] WData,
    input  logic              UART_Write_valid,
    input  logic              UART_Ready_To_Receive,
    input  logic              ResetCounters,
    input  logic              InstRetire,
    output logic [W_SIZE-1:0] RData,
    mmio_io_unit_if.master    uart
);
    localparam logic [W_SIZE-1:0] ADDR_STATUS = W_SIZE'(32'h8000_0000);
    localparam logic [W_SIZE-1:0] ADDR_RXDATA = W_SIZE'(32'h8000_0004);
    localparam logic [W_SIZE-1:0] ADDR_CYCLE  = W_SIZE'(32'h8000_0010);
    localparam logic [W_SIZE-1:0] ADDR_INSTR  = W_SIZE'(32'h8000_0014);

    logic              unused_wdata_hi;
    assign unused_wdata_hi = ^WData[W_SIZE-1:8];

    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_empty;
    logic              rx_full, rx_nonempty, rx_push, rx_pop;
    logic [7:0]        rx_head;
    logic [W_SIZE-1:0] cycle_q, cycle_d, inst_q, inst_d;
    logic [W_SIZE-1:0] rdata_q, rdata_d;

    assign tx_empty                    = !tx_valid_q;
    assign uart.uart_tx_data_out       = tx_data_q;
    assign uart.uart_tx_data_out_valid = tx_valid_q;
    assign uart.uart_rx_data_in_ready  = !rx_full && !rst;
    assign rx_push = uart.uart_rx_data_in_valid && uart.uart_rx_data_in_ready;
    // Pop looks only at registered state, so a same-cycle push into an empty buffer is invisible.
    assign rx_pop  = UART_Ready_To_Receive && rx_nonempty;
    assign RData   = rdata_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        if (UART_Write_valid && tx_empty) begin
            tx_data_d  = WData[7:0];
            tx_valid_d = 1'b1;
        end else if (tx_valid_q && uart.uart_tx_data_out_ready) begin
            tx_valid_d = 1'b0;
        end
    end

    always_comb begin
        cycle_d = ResetCounters ? '0 : cycle_q + W_SIZE'(1);
        inst_d  = ResetCounters ? '0 : inst_q + W_SIZE'(InstRetire);
    end

    always_comb begin
        rdata_d = '0;
        case (Addr)
            ADDR_STATUS: rdata_d = {{(W_SIZE-2){1'b0}}, rx_nonempty, tx_empty};
            ADDR_RXDATA: rdata_d = rx_nonempty ? W_SIZE'(rx_head) : '0;
            ADDR_CYCLE:  rdata_d = cycle_q;
            ADDR_INSTR:  rdata_d = inst_q;
            default:     rdata_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            cycle_q    <= '0;
            inst_q     <= '0;
            rdata_q    <= '0;
        end else begin
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cycle_q    <= cycle_d;
            inst_q     <= inst_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef MMIO_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [7:0]    rx_mem_q [RX_FIFO_DEPTH];
    logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;

    assign rx_nonempty = (rx_wr_q != rx_rd_q);
    assign rx_full     = (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]) && (rx_wr_q[AW] != rx_rd_q[AW]);
    assign rx_head     = rx_mem_q[rx_rd_q[AW-1:0]];

    always_comb begin
        rx_wr_d = rx_wr_q + PW'(rx_push);
        rx_rd_d = rx_rd_q + PW'(rx_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_q <= '0;
            rx_rd_q <= '0;
        end else begin
            rx_wr_q <= rx_wr_d;
            rx_rd_q <= rx_rd_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_q[AW-1:0]] <= uart.uart_rx_data_in;
        end
    end
`else
    localparam int UNUSED_RX_DEPTH = RX_FIFO_DEPTH;

    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;

    assign rx_nonempty = rx_valid_q;
    assign rx_full     = rx_valid_q;
    assign rx_head     = rx_data_q;

    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        if (rx_push) begin
            rx_valid_d = 1'b1;
            rx_data_d  = uart.uart_rx_data_in;
        end else if (rx_pop) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end
`endif
endmodule

// File: tb/tb_mmio_io_unit.sv
// Directed self-checking bench for mmio_io_unit; adapts RX depth to MMIO_RX_FIFO_EN.
module tb_mmio_io_unit;
`ifdef MMIO_RX_FIFO_EN
    localparam int RX_DEPTH = 8;
`else
    localparam int RX_DEPTH = 1;
`endif
    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RXDATA = 32'h8000_0004;
    localparam logic [31:0] A_TXDATA = 32'h8000_0008;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0010;
    localparam logic [31:0] A_INSTR  = 32'h8000_0014;
    localparam logic [31:0] A_RSTCNT = 32'h8000_0018;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Addr, WData, RData;
    logic        UART_Write_valid, UART_Ready_To_Receive, ResetCounters, InstRetire;
    int          checks = 0;
    int          failures = 0;

    mmio_io_unit_if u_if ();

    mmio_io_unit #(.W_SIZE(32), .RX_FIFO_DEPTH(RX_DEPTH)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .Addr                  (Addr),
        .WData                 (WData),
        .UART_Write_valid      (UART_Write_valid),
        .UART_Ready_To_Receive (UART_Ready_To_Receive),
        .ResetCounters         (ResetCounters),
        .InstRetire            (InstRetire),
        .RData                 (RData),
        .uart                  (u_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            u_if.uart_rx_data_in       = base + 8'(i);
            u_if.uart_rx_data_in_valid = 1'b1;
            check("rx_ready_before_push", 32'(u_if.uart_rx_data_in_ready), 32'd1);
            tick();
        end
        u_if.uart_rx_data_in_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary line");
        $fatal(1);
    end

    initial begin : stim
        rst = 1'b1;
        Addr = A_CYCLE;
        WData = '0;
        UART_Write_valid = 1'b0;
        UART_Ready_To_Receive = 1'b0;
        ResetCounters = 1'b0;
        InstRetire = 1'b0;
        u_if.uart_tx_data_out_ready = 1'b0;
        u_if.uart_rx_data_in = '0;
        u_if.uart_rx_data_in_valid = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_rdata", RData, 32'd0);
        check("rst_tx_valid", 32'(u_if.uart_tx_data_out_valid), 32'd0);
        check("rst_tx_data", 32'(u_if.uart_tx_data_out), 32'd0);
        check("rst_rx_ready", 32'(u_if.uart_rx_data_in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_rx_ready", 32'(u_if.uart_rx_data_in_ready), 32'd1);
        tick();
        check("cycle_after_rst", RData, 32'd0);
        Addr = A_INSTR;
        tick();
        check("instr_after_rst", RData, 32'd0);
        Addr = A_STATUS;
        tick();
        check("status_after_rst", RData, 32'h0000_0001);

        // TX holding register: blocked byte stays, second store dropped
        Addr = A_TXDATA;
        WData = 32'h0000_0041;
        UART_Write_valid = 1'b1;
        tick();
        UART_Write_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("tx_hold_valid", 32'(u_if.uart_tx_data_out_valid), 32'd1);
            check("tx_hold_data", 32'(u_if.uart_tx_data_out), 32'h41);
            tick();
        end
        WData = 32'h0000_0042;
        UART_Write_valid = 1'b1;
        tick();
        UART_Write_valid = 1'b0;
        check("tx_drop_data", 32'(u_if.uart_tx_data_out), 32'h41);
        check("tx_drop_valid", 32'(u_if.uart_tx_data_out_valid), 32'd1);
        Addr = A_STATUS;
        tick();
        check("status_tx_full", RData, 32'h0000_0000);
        u_if.uart_tx_data_out_ready = 1'b1;
        tick();
        u_if.uart_tx_data_out_ready = 1'b0;
        check("tx_drained_valid", 32'(u_if.uart_tx_data_out_valid), 32'd0);
        tick();
        check("status_tx_empty", RData, 32'h0000_0001);

        // Store in the same cycle as the draining handshake is dropped
        WData = 32'h0000_0055;
        UART_Write_valid = 1'b1;
        tick();
        WData = 32'h0000_0066;
        u_if.uart_tx_data_out_ready = 1'b1;
        tick();
        UART_Write_valid = 1'b0;
        u_if.uart_tx_data_out_ready = 1'b0;
        tick();
        check("tx_write_on_drain_valid", 32'(u_if.uart_tx_data_out_valid), 32'd0);
        check("tx_write_on_drain_data", 32'(u_if.uart_tx_data_out), 32'h55);

        // RX fill and drain twice to cover pointer wrap
        for (int rep = 0; rep < 2; rep++) begin
            push_bytes(8'h10 + 8'(rep * 32), RX_DEPTH);
            check("rx_full_ready", 32'(u_if.uart_rx_data_in_ready), 32'd0);
            Addr = A_STATUS;
            tick();
            check("status_rx_full", RData, 32'h0000_0003);
            Addr = A_RXDATA;
            UART_Ready_To_Receive = 1'b1;
            for (int i = 0; i < RX_DEPTH; i++) begin
                tick();
                check("rx_pop_order", RData, 32'h10 + 32'(rep * 32) + 32'(i));
            end
            tick();
            check("rx_pop_empty", RData, 32'd0);
            UART_Ready_To_Receive = 1'b0;
            Addr = A_STATUS;
            tick();
            check("status_rx_empty", RData, 32'h0000_0001);
        end

        // Full buffer: pop and incoming byte together, byte taken one cycle later
        push_bytes(8'h50, RX_DEPTH);
        u_if.uart_rx_data_in = 8'hAA;
        u_if.uart_rx_data_in_valid = 1'b1;
        Addr = A_RXDATA;
        UART_Ready_To_Receive = 1'b1;
        check("full_pop_ready", 32'(u_if.uart_rx_data_in_ready), 32'd0);
        tick();
        check("full_pop_data", RData, 32'h50);
        UART_Ready_To_Receive = 1'b0;
        check("after_pop_ready", 32'(u_if.uart_rx_data_in_ready), 32'd1);
        tick();
        u_if.uart_rx_data_in_valid = 1'b0;
        UART_Ready_To_Receive = 1'b1;
        for (int i = 1; i < RX_DEPTH; i++) begin
            tick();
            check("full_drain_order", RData, 32'h50 + 32'(i));
        end
        tick();
        check("full_drain_late_byte", RData, 32'hAA);
        tick();
        check("full_drain_empty", RData, 32'd0);
        UART_Ready_To_Receive = 1'b0;

        // Push into empty buffer is not visible to a pop in the same cycle
        u_if.uart_rx_data_in = 8'h77;
        u_if.uart_rx_data_in_valid = 1'b1;
        UART_Ready_To_Receive = 1'b1;
        tick();
        u_if.uart_rx_data_in_valid = 1'b0;
        check("push_pop_empty", RData, 32'd0);
        tick();
        check("push_pop_empty_next", RData, 32'h77);
        UART_Ready_To_Receive = 1'b0;
        Addr = A_STATUS;
        tick();
        check("push_pop_empty_status", RData, 32'h0000_0001);

`ifdef MMIO_RX_FIFO_EN
        // Half-full: push and pop in one cycle keep the count
        push_bytes(8'h60, 4);
        Addr = A_RXDATA;
        u_if.uart_rx_data_in = 8'h64;
        u_if.uart_rx_data_in_valid = 1'b1;
        UART_Ready_To_Receive = 1'b1;
        tick();
        u_if.uart_rx_data_in_valid = 1'b0;
        check("half_pushpop_data", RData, 32'h60);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("half_drain_order", RData, 32'h60 + 32'(i));
        end
        tick();
        check("half_drain_empty", RData, 32'd0);
        UART_Ready_To_Receive = 1'b0;
`endif

        // Counters
        Addr = A_RSTCNT;
        ResetCounters = 1'b1;
        tick();
        ResetCounters = 1'b0;
        for (int i = 0; i < 10; i++) begin
            InstRetire = (i == 0 || i == 2 || i == 3 || i == 6 || i == 8);
            tick();
        end
        InstRetire = 1'b0;
        Addr = A_INSTR;
        tick();
        check("instret_5_of_10", RData, 32'd5);
        Addr = A_CYCLE;
        tick();
        check("cycle_after_10", RData, 32'd11);
        Addr = A_INSTR;
        ResetCounters = 1'b1;
        InstRetire = 1'b1;
        tick();
        check("instret_pre_clear", RData, 32'd5);
        ResetCounters = 1'b0;
        InstRetire = 1'b0;
        Addr = A_CYCLE;
        tick();
        check("cycle_cleared", RData, 32'd0);
        Addr = A_INSTR;
        tick();
        check("instret_cleared", RData, 32'd0);

        // Cycle counter wrap
        Addr = A_CYCLE;
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        tick();
        check("cycle_max", RData, 32'hFFFF_FFFF);
        tick();
        check("cycle_wrap", RData, 32'd0);

        // Reset mid-transfer discards TX and RX contents
        Addr = A_TXDATA;
        WData = 32'h0000_0099;
        UART_Write_valid = 1'b1;
        tick();
        UART_Write_valid = 1'b0;
        push_bytes(8'h20, (RX_DEPTH < 3) ? RX_DEPTH : 3);
        rst = 1'b1;
        u_if.uart_rx_data_in = 8'hEE;
        u_if.uart_rx_data_in_valid = 1'b1;
        tick();
        check("mid_rst_rx_ready", 32'(u_if.uart_rx_data_in_ready), 32'd0);
        rst = 1'b0;
        u_if.uart_rx_data_in_valid = 1'b0;
        Addr = A_STATUS;
        check("mid_rst_tx_valid", 32'(u_if.uart_tx_data_out_valid), 32'd0);
        check("mid_rst_tx_data", 32'(u_if.uart_tx_data_out), 32'd0);
        tick();
        check("mid_rst_status", RData, 32'h0000_0001);
        Addr = A_RXDATA;
        UART_Ready_To_Receive = 1'b1;
        tick();
        check("mid_rst_pop", RData, 32'd0);
        UART_Ready_To_Receive = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_io_unit.md
# mmio_io_unit

Memory-mapped I/O responder for the 0x8000_00xx window. It consumes the XM-stage UART and counter strobes plus the ALU address, buffers transmit and receive bytes between the CPU and the serial UART blocks, and keeps the cycle and retired-instruction counters. It returns registered load data to the M/W stage with the same one-cycle latency as data memory.

## Interface
- W_SIZE, 32, datapath width
- RX_FIFO_DEPTH, 8, RX FIFO entries (power of two, ≥2); used only with MMIO_RX_FIFO_EN

- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- Addr  in  W_SIZE  XM-stage ALU result (load/store address)
- WData  in  W_SIZE  store data; only [7:0] used
- UART_Write_valid  in  1  store to 0x80000008 this cycle
- UART_Ready_To_Receive  in  1  load from 0x80000004 this cycle (pop)
- ResetCounters  in  1  store to 0x80000018 this cycle
- InstRetire  in  1  one instruction retires this cycle
- RData  out  W_SIZE  registered read data for the load issued last cycle
- uart_tx_data_out  out  8  byte to serial transmitter
- uart_tx_data_out_valid  out  1  TX byte valid
- uart_tx_data_out_ready  in  1  transmitter accepts byte
- uart_rx_data_in  in  8  byte from serial receiver
- uart_rx_data_in_valid  in  1  RX byte valid
- uart_rx_data_in_ready  out  1  RX buffer has space

## Operation
- Read map (sampled on Addr every cycle, registered into RData):
  - 0x80000000: {30'b0, rx_nonempty, tx_empty}
  - 0x80000004: zero-extended RX head byte (0 if RX empty)
  - 0x80000010: cycle counter
  - 0x80000014: instruction counter
  - any other address: 0
- TX: single-entry holding register. UART_Write_valid with tx_empty loads WData[7:0] and sets valid. UART_Write_valid with tx full drops the byte; software polls bit 0. Valid&&ready clears the entry. A write in the same cycle as the draining handshake is dropped, because the write checks the registered full flag.
- RX: uart_rx_data_in_ready = !rx_full && !rst. Push on valid&&ready. UART_Ready_To_Receive with RX non-empty pops the head; the byte returned is the pre-pop head. A pop when empty changes no state and returns 0. Push and pop in the same cycle are both performed and the count is unchanged. A push into an empty buffer is not visible to a pop in that same cycle.
- Counters: both 32-bit and wrap 0xFFFFFFFF→0. The cycle counter increments every cycle. The instruction counter increments when InstRetire is high. ResetCounters forces both to 0 at the next edge, overriding any increment. A read returns the value before that edge.

## Timing
- RData is valid one cycle after Addr/UART_Ready_To_Receive are presented.
- RX pop and TX load take effect at the same edge that registers RData.
- Reset values:
  - RData = 0
  - uart_tx_data_out = 0, uart_tx_data_out_valid = 0
  - RX empty, pointers 0, uart_rx_data_in_ready = 0 during rst and 1 the cycle after
  - both counters = 0
- rst asserted mid-transfer discards the pending TX byte and all RX contents. No handshake completes in a reset cycle.
- uart_tx_data_out is stable while valid is high and ready is low.

## Configuration
- MMIO_RX_FIFO_EN defined: RX uses a circular FIFO of RX_FIFO_DEPTH entries. Read/write pointers carry one extra wrap bit; full is declared when the indices match and the wrap bits differ.
- Undefined: RX is a single holding register (depth 1), and RX_FIFO_DEPTH is ignored. Full is the same as non-empty.

## Test plan
- Reset, then read 0x80000000 → RData=0x00000001 one cycle later; counters read 0; tx valid=0.
- Store 0x41 to 0x80000008 with tx ready held low 3 cycles, then a second store 0x42 → tx_data_out stays 0x41, valid stays 1, and 0x42 is dropped. Raise ready → valid drops next cycle and bit0 returns 1.
- Push 0x10..0x17 (FIFO on, depth 8) → ready=0 after 8th push. Pop 8 times → RData 0x10..0x17 in order, then a 9th pop returns 0 and status bit1=0. Cover pointer wrap by repeating twice.
- Full FIFO with a simultaneous pop and valid byte → byte is not accepted that cycle and is accepted next cycle. Half-full FIFO with a push and pop in one cycle → count unchanged.
- Assert InstRetire on 5 of 10 cycles → instruction counter reads 5. ResetCounters while InstRetire=1 → both read 0 after the edge. Preload cycle counter to 0xFFFFFFFF → reads 0 next cycle.
- Assert rst with a pending TX byte and 3 RX bytes → valid=0, status=0x00000001, pop returns 0.
